// File: rtl/frame_buf_ctrl_if.sv
// Handshake and data_mem strobe bundle for the ping-pong frame buffer controller.
// The master side is the writer/reader client; the slave side is the controller.
interface frame_buf_ctrl_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int CNT_WIDTH  = 8
);
    logic                  wr_req;
    logic                  wr_sof;
    logic                  wr_ready;
    logic                  rd_req;
    logic                  rd_ready;
    logic                  rd_valid;
    logic                  rd_eof;
    logic                  mem_wr_n;
    logic                  mem_rd_n;
    logic [ADDR_WIDTH:0]   mem_wr_addr;
    logic [ADDR_WIDTH:0]   mem_rd_addr;
    logic [1:0]            buf_full;
    logic [CNT_WIDTH-1:0]  frames_dropped;

    modport master (
        output wr_req, wr_sof, rd_req,
        input  wr_ready, rd_ready, rd_valid, rd_eof, mem_wr_n, mem_rd_n,
               mem_wr_addr, mem_rd_addr, buf_full, frames_dropped
    );

    modport slave (
        input  wr_req, wr_sof, rd_req,
        output wr_ready, rd_ready, rd_valid, rd_eof, mem_wr_n, mem_rd_n,
               mem_wr_addr, mem_rd_addr, buf_full, frames_dropped
    );
endinterface

// File: rtl/frame_buf_ctrl.sv
// Ping-pong controller that splits one data_mem into two frame buffers: the writer
// fills one while the reader drains the other, swapping only at frame boundaries.
module frame_buf_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int FRAME_LEN  = 1 << ADDR_WIDTH,
    parameter int CNT_WIDTH  = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    frame_buf_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} buf_st_e;
    typedef enum logic {W_IDLE, W_FILL}  wr_st_e;
    typedef enum logic {R_IDLE, R_DRAIN} rd_st_e;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FRAME_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

    buf_st_e                buf_q [2];
    buf_st_e                buf_d [2];
    wr_st_e                 w_st_q, w_st_d;
    rd_st_e                 r_st_q, r_st_d;
    logic                   wbuf_q, wbuf_d, rbuf_q, rbuf_d;
    logic                   last_wbuf_q, last_wbuf_d;
    logic                   first_full_q, first_full_d;
    logic [ADDR_WIDTH-1:0]  woff_q, woff_d, roff_q, roff_d;
    logic [CNT_WIDTH-1:0]   drop_q, drop_d;
    logic                   rd_valid_q, rd_valid_d, rd_eof_q, rd_eof_d;

    logic                   any_empty, any_full, wsel, rsel;
    logic                   wr_start, wr_drop, wr_beat, wr_issue, wr_buf;
    logic                   rd_start, rd_beat, rd_issue, rd_buf;
    logic [ADDR_WIDTH-1:0]  wr_off, rd_off;

    // Decode from registered state only, so a buffer changing hands this edge
    // is invisible to the other side until the next cycle.
    always_comb begin
        any_empty = (buf_q[0] == B_EMPTY) || (buf_q[1] == B_EMPTY);
        any_full  = (buf_q[0] == B_FULL)  || (buf_q[1] == B_FULL);
        wsel      = (buf_q[~last_wbuf_q] == B_EMPTY) ? ~last_wbuf_q : last_wbuf_q;
        if ((buf_q[0] == B_FULL) && (buf_q[1] == B_FULL)) rsel = first_full_q;
        else                                              rsel = (buf_q[0] == B_FULL) ? 1'b0 : 1'b1;

        wr_start = (w_st_q == W_IDLE) && bus.wr_req && bus.wr_sof && any_empty;
        wr_drop  = (w_st_q == W_IDLE) && bus.wr_req && bus.wr_sof && !any_empty;
        wr_beat  = (w_st_q == W_FILL) && bus.wr_req;
        wr_issue = wr_start || wr_beat;
        wr_buf   = (w_st_q == W_IDLE) ? wsel : wbuf_q;
        wr_off   = ((w_st_q == W_IDLE) || bus.wr_sof) ? '0 : woff_q;

        rd_start = (r_st_q == R_IDLE) && bus.rd_req && any_full;
        rd_beat  = (r_st_q == R_DRAIN) && bus.rd_req;
        rd_issue = rd_start || rd_beat;
        rd_buf   = (r_st_q == R_IDLE) ? rsel : rbuf_q;
        rd_off   = (r_st_q == R_IDLE) ? '0 : roff_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            buf_q[0]     <= B_EMPTY;
            buf_q[1]     <= B_EMPTY;
            w_st_q       <= W_IDLE;
            r_st_q       <= R_IDLE;
            wbuf_q       <= 1'b0;
            rbuf_q       <= 1'b0;
            last_wbuf_q  <= 1'b1;
            first_full_q <= 1'b0;
            woff_q       <= '0;
            roff_q       <= '0;
            drop_q       <= '0;
            rd_valid_q   <= 1'b0;
            rd_eof_q     <= 1'b0;
        end else begin
            buf_q[0]     <= buf_d[0];
            buf_q[1]     <= buf_d[1];
            w_st_q       <= w_st_d;
            r_st_q       <= r_st_d;
            wbuf_q       <= wbuf_d;
            rbuf_q       <= rbuf_d;
            last_wbuf_q  <= last_wbuf_d;
            first_full_q <= first_full_d;
            woff_q       <= woff_d;
            roff_q       <= roff_d;
            drop_q       <= drop_d;
            rd_valid_q   <= rd_valid_d;
            rd_eof_q     <= rd_eof_d;
        end
    end

    always_comb begin
        buf_d[0]     = buf_q[0];
        buf_d[1]     = buf_q[1];
        w_st_d       = w_st_q;
        r_st_d       = r_st_q;
        wbuf_d       = wbuf_q;
        rbuf_d       = rbuf_q;
        last_wbuf_d  = last_wbuf_q;
        first_full_d = first_full_q;
        woff_d       = woff_q;
        roff_d       = roff_q;
        drop_d       = drop_q;
        rd_valid_d   = rd_issue;
        rd_eof_d     = rd_issue && (rd_off == LAST);

        if (wr_start) begin
            buf_d[wsel] = B_FILLING;
            wbuf_d      = wsel;
            woff_d      = ONE;
            w_st_d      = W_FILL;
        end
        if (wr_drop && (drop_q != '1)) drop_d = drop_q + CNT_WIDTH'(1);
        if (wr_beat) begin
            if (bus.wr_sof) begin
                woff_d = ONE;
            end else if (woff_q == LAST) begin
                buf_d[wbuf_q] = B_FULL;
                w_st_d        = W_IDLE;
                woff_d        = '0;
                last_wbuf_d   = wbuf_q;
                // Oldest-full pointer: the other buffer stays first if it is already full.
                first_full_d  = (buf_q[~wbuf_q] == B_FULL) ? ~wbuf_q : wbuf_q;
            end else begin
                woff_d = woff_q + ONE;
            end
        end

        if (rd_start) begin
            buf_d[rsel] = B_DRAINING;
            rbuf_d      = rsel;
            roff_d      = ONE;
            r_st_d      = R_DRAIN;
        end
        if (rd_beat) begin
            if (roff_q == LAST) begin
                buf_d[rbuf_q] = B_EMPTY;
                r_st_d        = R_IDLE;
                roff_d        = '0;
            end else begin
                roff_d = roff_q + ONE;
            end
        end
    end

    always_comb begin
        bus.mem_wr_n       = !wr_issue;
        bus.mem_wr_addr    = {wr_buf, wr_off};
        bus.mem_rd_n       = !rd_issue;
        bus.mem_rd_addr    = {rd_buf, rd_off};
        bus.wr_ready       = (w_st_q == W_FILL) || any_empty;
        bus.rd_ready       = (r_st_q == R_DRAIN) || any_full;
        bus.rd_valid       = rd_valid_q;
        bus.rd_eof         = rd_eof_q;
        bus.buf_full       = {buf_q[1] == B_FULL, buf_q[0] == B_FULL};
        bus.frames_dropped = drop_q;
    end
endmodule
